// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / data hazard stalls, taken-branch
// flush, data-memory wait freeze with timeout, and an optional operand
// forwarding unit enabled by defining PIPE_FWD_UNIT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             ex_rs,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_mread,
    input  logic                   ex_regwrite,
    input  logic [4:0]             ex_dst,
    input  logic                   mem_regwrite,
    input  logic [4:0]             mem_dst,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_dst,
    input  logic                   mem_branch,
    input  logic                   mem_zero,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_bubble,
    output logic                   pipe_freeze,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;

    logic load_use;
    logic data_haz;
    logic br_taken;
    logic mem_stall;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    assign load_use  = ex_mread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign br_taken  = mem_branch && mem_zero;
    assign mem_stall = dmem_req && !dmem_ready && !mem_err;

`ifdef PIPE_FWD_UNIT_EN
    // Forwarding resolves ALU results, so only a load in EX still needs a stall.
    logic unused_ex_wr;
    assign unused_ex_wr = ^{ex_regwrite, ex_dst};
    assign data_haz     = load_use;

    // EX/MEM result is newer than MEM/WB, so it wins.
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_rs))
            fwd_a_raw = 2'b10;
        else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_rs))
            fwd_a_raw = 2'b01;
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_dst == ex_rt))
            fwd_b_raw = 2'b10;
        else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_rt))
            fwd_b_raw = 2'b01;
    end
`else
    // No forwarding: any pending write in EX or MEM to an ID source must stall.
    // WB is safe because the register file writes in the first half-cycle.
    logic unused_fwd_in;
    logic ex_wr_haz;
    logic mem_wr_haz;
    assign unused_fwd_in = ^{ex_rs, wb_regwrite, wb_dst};
    assign ex_wr_haz  = ex_regwrite && (ex_dst != 5'd0) && ((ex_dst == id_rs) || (ex_dst == id_rt));
    assign mem_wr_haz = mem_regwrite && (mem_dst != 5'd0) && ((mem_dst == id_rs) || (mem_dst == id_rt));
    assign data_haz   = load_use || ex_wr_haz || mem_wr_haz;
    assign fwd_a_raw  = 2'b00;
    assign fwd_b_raw  = 2'b00;
`endif

    // Pipeline control: memory freeze beats branch flush beats data-hazard stall.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        forward_a     = 2'b00;
        forward_b     = 2'b00;
        if (!rst) begin
            forward_a = fwd_a_raw;
            forward_b = fwd_b_raw;
            if (mem_stall) begin
                pipe_freeze = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (br_taken) begin
                if_id_flush   = 1'b1;
                id_ex_bubble  = 1'b1;
                ex_mem_bubble = 1'b1;
            end else if (data_haz) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Memory wait FSM; wcnt counts stalled cycles so a hung memory raises mem_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
                        mem_err <= 1'b1;
                        state   <= RUN;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (!pc_write && (stall_count != {STALL_CNT_W{1'b1}}))
            stall_count <= stall_count + STALL_CNT_W'(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 8, SHALL set the max cycles waited for dmem_ready before error.
REQ-002 Parameter STALL_CNT_W, default 16, SHALL set the stall_count width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 id_rs, id_rt  in  5 each  SHALL be the source registers of the instruction in ID.
REQ-006 ex_rs, ex_rt  in  5 each  SHALL be the ID/EX source registers.
REQ-007 ex_mread, ex_regwrite  in  1 each  SHALL be the ID/EX MemRead and RegWrite controls.
REQ-008 ex_dst  in  5  SHALL be the EX-stage RegDst mux output.
REQ-009 mem_regwrite, mem_dst  in  1, 5  SHALL be the EX/MEM RegWrite and destination.
REQ-010 wb_regwrite, wb_dst  in  1, 5  SHALL be the MEM/WB RegWrite and destination.
REQ-011 mem_branch, mem_zero  in  1 each  SHALL be the EX/MEM Branch and Zero.
REQ-012 dmem_req, dmem_ready  in  1 each  SHALL be the MEM-stage access request (MRead|MWrite) and the memory completion flag.
REQ-013 pc_write, if_id_write  out  1 each  SHALL enable PC and IF/ID loading.
REQ-014 if_id_flush, id_ex_bubble, ex_mem_bubble  out  1 each  SHALL clear IF/ID or zero ID/EX / EX/MEM controls.
REQ-015 pipe_freeze  out  1  SHALL hold every pipeline register.
REQ-016 forward_a, forward_b  out  2 each  SHALL select ALU operands: 00 register, 10 EX/MEM, 01 MEM/WB.
REQ-017 mem_err  out  1  SHALL flag a memory timeout (sticky).
REQ-018 stall_count  out  STALL_CNT_W  SHALL count cycles with pc_write=0.

Function
REQ-019 FSM states SHALL be RUN and MEM_WAIT, plus a wait counter wcnt of clog2(MEM_TIMEOUT+1) bits.
REQ-020 Hazard outputs SHALL be combinational from inputs and state, acting in the cycle the condition is present.
REQ-021 Load-use SHALL be ex_mread && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt); effect: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-022 Branch taken (mem_branch && mem_zero) SHALL give pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1, and SHALL override load-use.
REQ-023 Memory stall (dmem_req && !dmem_ready && !mem_err) SHALL give pipe_freeze=1, pc_write=0, if_id_write=0, all flush/bubble=0, and SHALL override branch and load-use.
REQ-024 RUN->MEM_WAIT on memory stall with wcnt loaded to 1; MEM_WAIT->RUN when dmem_ready=1 (freeze released that same cycle) with wcnt cleared.
REQ-025 In MEM_WAIT wcnt SHALL increment per cycle; on reaching MEM_TIMEOUT mem_err SHALL set, freeze SHALL drop next cycle, FSM SHALL return to RUN.
REQ-026 Once mem_err=1, memory stalls SHALL be ignored until reset.
REQ-027 With no condition active: pc_write=1, if_id_write=1, all others 0.
REQ-028 stall_count SHALL increment each cycle pc_write=0 and saturate at all-ones.
REQ-029 Register 0 SHALL never match for hazard or forwarding.

Reset
REQ-030 On rst: state RUN, wcnt 0, mem_err 0, stall_count 0; combinational outputs SHALL follow REQ-027 while rst is held.

Configuration
REQ-031 Macro PIPE_FWD_UNIT_EN defined SHALL compile forwarding: forward_a=10 if mem_regwrite && mem_dst==ex_rs, else 01 if wb_regwrite && wb_dst==ex_rs, else 00; forward_b likewise with ex_rt; only load-use stalls.
REQ-032 Macro undefined SHALL tie forward_a/forward_b to 00 and treat as hazard (REQ-021 effect) any ex_regwrite/ex_dst or mem_regwrite/mem_dst match on id_rs/id_rt; register file writes first half-cycle, so WB is never a hazard.

Verification
REQ-033 ex_mread=1, ex_rt=5, id_rs=5 -> one cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1.
REQ-034 Load-use plus mem_branch=1, mem_zero=1 same cycle -> pc_write=1, if_id_flush=id_ex_bubble=ex_mem_bubble=1.
REQ-035 dmem_req=1, dmem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, 0 on ready cycle, FSM RUN.
REQ-036 dmem_ready never high, MEM_TIMEOUT=8 -> mem_err=1 after 8 wait cycles, freeze drops next cycle, later dmem_req ignored.
REQ-037 With PIPE_FWD_UNIT_EN, mem_dst=wb_dst=ex_rs=3, both regwrite=1 -> forward_a=10; ex_rs=0 -> 00; without macro, mem_dst=id_rt=7 -> stall.
REQ-038 rst asserted mid-MEM_WAIT -> immediately RUN, pipe_freeze=0, mem_err=0, stall_count=0.
